arms_fetch_stage: RTL and testbench
===================================

// Module: arms_fetch_stage
// PURPOSE
//   Instruction-fetch stage and IF/ID pipeline register for the ARMS 64-bit LEGv8 pipeline.
//   Owns the PC and drives iaddrbus to instruction memory. Captures ibus into the IF/ID
//   register for the decode stage. Applies stall holds and branch redirects from decode.
//   Keeps a saturating count of fetched instructions for the bench.
// PARAMETERS
//   ADDR_W    64          PC / iaddrbus width
//   INSTR_W   32          instruction width
//   RESET_PC  64'h0       PC value loaded on reset
//   CNT_W     32          fetch_count width
// PORTS
//   clk            in   1        rising-edge clock
//   reset          in   1        asynchronous, active-low reset
//   ibus           in   INSTR_W  instruction returned for current iaddrbus (combinational memory)
//   iaddrbus       out  ADDR_W   current PC; registered
//   stall          in   1        decode hazard; hold PC and IF/ID
//   branch_taken   in   1        decode resolved a taken B/CBZ/CBNZ/B.cond
//   branch_target  in   ADDR_W   redirect address
//   if_id_instr    out  INSTR_W  instruction handed to decode
//   if_id_pc       out  ADDR_W   address of if_id_instr
//   if_id_valid    out  1        1 = real instruction, 0 = bubble (if_id_instr = 0, NOP)
//   fetch_count    out  CNT_W    number of valid instructions loaded into IF/ID
// BEHAVIOUR
//   - Reset (reset=0, async): iaddrbus=RESET_PC, if_id_instr=0, if_id_pc=0,
//     if_id_valid=0, fetch_count=0. The first rising edge after release is a normal fetch.
//   - Latency: the instruction at address A is on ibus while iaddrbus==A.
//     It appears on if_id_instr/if_id_pc=A one edge later.
//   - Priority at each edge: stall > branch_taken > sequential.
//   - stall=1: PC, IF/ID and fetch_count hold. branch_taken is ignored;
//     decode re-asserts it after the stall clears.
//   - branch_taken=1 (no stall): PC <= {branch_target[ADDR_W-1:2],2'b00}.
//     if_id_pc <= PC. The if_id_instr/valid update follows the macro rule below.
//   - Sequential: PC <= PC+4, with modulo 2^ADDR_W wrap
//     (64'hFFFF_FFFF_FFFF_FFFC -> 0). IF/ID <= {ibus, PC, valid=1}.
//   - fetch_count increments on each edge where IF/ID loads with valid=1.
//     It saturates at all-ones; it never wraps.
//   - An ibus value of 32'b0 is still counted as valid; NOP filtering belongs to decode.
//   - Misaligned reset: RESET_PC[1:0] is forced to 0.
//   - Reset asserted mid-stall or mid-redirect: all state returns to reset values at once.
//     A pending redirect is lost.
// CONFIGURATION
//   ARMS_FETCH_DELAY_SLOT_EN
//     defined: branch delay slot. On a taken branch, IF/ID <= {ibus, PC, valid=1};
//       the slot instruction executes and is counted.
//     undefined (default): the wrong-path fetch is flushed. On a taken branch,
//       IF/ID <= {32'b0, PC, valid=0}; fetch_count does not increment.
// TESTING
//   1 reset low 2 cycles, release -> iaddrbus=0, if_id_valid=0;
//     edge1: if_id_pc=0, if_id_instr=ibus@0, iaddrbus=4
//   2 free run 30 edges with ibus=addr-tagged words -> iaddrbus steps 0,4,8..0x74;
//     fetch_count=30
//   3 stall high 3 edges at iaddrbus=0x20 -> iaddrbus, if_id_* and fetch_count frozen;
//     resume at 0x24
//   4 branch_taken with target=0x103 at iaddrbus=0x40 -> next iaddrbus=0x100;
//     if_id_pc=0x40; valid=0 (default) or 1 (macro)
//   5 stall and branch_taken together, target=0x200 -> no redirect;
//     PC holds; iaddrbus != 0x200
//   6 preload PC 64'hFFFF_FFFF_FFFF_FFFC via branch, one edge -> iaddrbus=0;
//     reset pulse mid-run -> all outputs return to reset values asynchronously

Source files
------------

// File: rtl/arms_fetch_stage.sv
// arms_fetch_stage -- instruction fetch and IF/ID pipeline register (ARMS LEGv8).
//
// Owns the PC and drives it on iaddrbus. Instruction memory is combinational:
// ibus carries the word for the current iaddrbus. Each unstalled edge loads
// IF/ID with that word and its address. Decode can stall (hold everything) or
// redirect the PC to branch_target. fetch_count is a saturating count of valid
// instructions loaded into IF/ID.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-low reset
//   ibus          in   instruction at iaddrbus
//   iaddrbus      out  current PC (registered)
//   stall         in   hold PC, IF/ID and fetch_count
//   branch_taken  in   redirect PC to branch_target (ignored while stalled)
//   branch_target in   redirect address, low two bits dropped
//   if_id_instr   out  instruction handed to decode (0 for a bubble)
//   if_id_pc      out  address of if_id_instr
//   if_id_valid   out  1 = real instruction, 0 = bubble
//   fetch_count   out  saturating count of valid IF/ID loads
//
// Build option: define ARMS_FETCH_DELAY_SLOT_EN for a branch delay slot (the
// instruction fetched alongside a taken branch is kept and counted). Undefined,
// that wrong-path fetch is replaced with a bubble.

module arms_fetch_stage #(
    parameter int unsigned       ADDR_W   = 64,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       CNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] ibus,
    output logic [ADDR_W-1:0]  iaddrbus,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic               if_id_valid,
    output logic [CNT_W-1:0]   fetch_count
);

`ifdef ARMS_FETCH_DELAY_SLOT_EN
    localparam bit DELAY_SLOT = 1'b1;
`else
    localparam bit DELAY_SLOT = 1'b0;
`endif

    // Instructions are word aligned, so a misaligned reset vector is truncated.
    localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:2], 2'b00};

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_next;
    logic [INSTR_W-1:0] instr_next;
    logic [ADDR_W-1:0]  id_pc_next;
    logic               valid_next;
    logic               load_valid;
    logic [CNT_W-1:0]   cnt_next;

    assign iaddrbus = pc;

    always_comb begin
        pc_next    = pc;
        instr_next = if_id_instr;
        id_pc_next = if_id_pc;
        valid_next = if_id_valid;
        load_valid = 1'b0;
        cnt_next   = fetch_count;

        if (!stall) begin
            id_pc_next = pc;
            if (branch_taken) begin
                pc_next    = {branch_target[ADDR_W-1:2], 2'b00};
                instr_next = DELAY_SLOT ? ibus : '0;
                valid_next = DELAY_SLOT;
            end else begin
                pc_next    = pc + ADDR_W'(4);
                instr_next = ibus;
                valid_next = 1'b1;
            end
            load_valid = valid_next;
        end

        // Saturate instead of wrapping.
        if (load_valid && (fetch_count != '1)) begin
            cnt_next = fetch_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC_ALIGNED;
            if_id_instr <= '0;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            pc          <= pc_next;
            if_id_instr <= instr_next;
            if_id_pc    <= id_pc_next;
            if_id_valid <= valid_next;
            fetch_count <= cnt_next;
        end
    end

endmodule

// File: tb/tb_arms_fetch_stage.sv
module tb_arms_fetch_stage;

`ifdef ARMS_FETCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;

    logic [31:0] ibus, ibus2;
    logic [63:0] iaddrbus, iaddrbus2;
    logic [31:0] if_id_instr, if_id_instr2;
    logic [63:0] if_id_pc, if_id_pc2;
    logic        if_id_valid, if_id_valid2;
    logic [31:0] fetch_count;
    logic [2:0]  fetch_count2;

    int unsigned total  = 0;
    int unsigned passed = 0;

    always #5 clk = ~clk;

    // Address-tagged memory; address 0x10 holds an all-zero word.
    function automatic logic [31:0] ibus_of(logic [63:0] a);
        if (a[31:0] == 32'h10) return 32'h0;
        return 32'hA500_0000 ^ a[31:0];
    endfunction

    assign ibus  = ibus_of(iaddrbus);
    assign ibus2 = ibus_of(iaddrbus2);

    arms_fetch_stage dut (
        .clk(clk), .reset(reset), .ibus(ibus), .iaddrbus(iaddrbus),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_valid(if_id_valid), .fetch_count(fetch_count)
    );

    // Narrow counter (saturates at 7) and misaligned reset vector 0x13 -> 0x10.
    arms_fetch_stage #(.CNT_W(3), .RESET_PC(64'h13)) dut_sat (
        .clk(clk), .reset(reset), .ibus(ibus2), .iaddrbus(iaddrbus2),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .if_id_instr(if_id_instr2), .if_id_pc(if_id_pc2),
        .if_id_valid(if_id_valid2), .fetch_count(fetch_count2)
    );

    typedef struct {
        logic [63:0] pc;
        logic [63:0] ipc;
        logic [31:0] ins;
        logic        v;
        logic [31:0] cnt;
    } mdl_t;

    typedef struct {
        mdl_t a;
        mdl_t b;
    } exp_t;

    mdl_t  m1, m2;
    exp_t  exp_q[$];
    string tag_q[$];
    event  chk_ev;

    function automatic mdl_t adv(mdl_t m, logic st, logic bt, logic [63:0] tgt,
                                 logic [31:0] cmax);
        mdl_t r;
        logic ld;
        r  = m;
        ld = 1'b0;
        if (!st) begin
            r.ipc = m.pc;
            if (bt) begin
                r.ins = DS ? ibus_of(m.pc) : 32'h0;
                r.v   = DS;
                ld    = DS;
                r.pc  = {tgt[63:2], 2'b00};
            end else begin
                r.ins = ibus_of(m.pc);
                r.v   = 1'b1;
                ld    = 1'b1;
                r.pc  = m.pc + 64'd4;
            end
            if (ld && (m.cnt < cmax)) r.cnt = m.cnt + 32'd1;
        end
        return r;
    endfunction

    task automatic push(string t);
        exp_t e;
        e.a = m1;
        e.b = m2;
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    // One clock: apply inputs, predict the post-edge state, advance to next negedge.
    task automatic step(logic st, logic bt, logic [63:0] tgt, string t);
        stall         = st;
        branch_taken  = bt;
        branch_target = tgt;
        m1 = adv(m1, st, bt, tgt, 32'hFFFF_FFFF);
        m2 = adv(m2, st, bt, tgt, 32'd7);
        push(t);
        @(negedge clk);
    endtask

    // Reset values are checked asynchronously, away from any clock edge.
    task automatic push_reset(string t);
        m1 = '{pc: 64'h0,  ipc: 64'h0, ins: 32'h0, v: 1'b0, cnt: 32'h0};
        m2 = '{pc: 64'h10, ipc: 64'h0, ins: 32'h0, v: 1'b0, cnt: 32'h0};
        push(t);
        ->chk_ev;
    endtask

    task automatic chk(string t, string f, logic [63:0] act, logic [63:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s.%s: got %h expected %h", t, f, act, expv);
    endtask

    // Monitor: outputs are presented after every clock edge (or on request for
    // async reset); pop one expectation each time and compare.
    initial begin
        exp_t  e;
        string t;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                chk(t, "iaddrbus",     iaddrbus,               e.a.pc);
                chk(t, "if_id_pc",     if_id_pc,               e.a.ipc);
                chk(t, "if_id_instr",  {32'h0, if_id_instr},   {32'h0, e.a.ins});
                chk(t, "if_id_valid",  {63'h0, if_id_valid},   {63'h0, e.a.v});
                chk(t, "fetch_count",  {32'h0, fetch_count},   {32'h0, e.a.cnt});
                chk(t, "iaddrbus2",    iaddrbus2,              e.b.pc);
                chk(t, "if_id_pc2",    if_id_pc2,              e.b.ipc);
                chk(t, "if_id_instr2", {32'h0, if_id_instr2},  {32'h0, e.b.ins});
                chk(t, "if_id_valid2", {63'h0, if_id_valid2},  {63'h0, e.b.v});
                chk(t, "fetch_count2", {61'h0, fetch_count2},  {32'h0, e.b.cnt});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 64'h0;
        repeat (2) @(negedge clk);
        push_reset("rst_init");
        #2 reset = 1'b1;

        // Free run from 0: addresses 0..0x74, includes the zero word at 0x10.
        repeat (30) step(1'b0, 1'b0, 64'h0, "run");

        // Async reset pulse between edges.
        #1 reset = 1'b0;
        push_reset("rst_async");
        #2 reset = 1'b1;

        repeat (8) step(1'b0, 1'b0, 64'h0, "to_20");
        repeat (3) step(1'b1, 1'b0, 64'h0, "stall");
        repeat (8) step(1'b0, 1'b0, 64'h0, "to_40");

        step(1'b0, 1'b1, 64'h103, "br_103");
        step(1'b1, 1'b1, 64'h200, "stall_br");
        step(1'b0, 1'b0, 64'h0, "after_br");
        step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, "br_top");
        step(1'b0, 1'b0, 64'h0, "wrap");
        step(1'b0, 1'b0, 64'h0, "wrap1");
        step(1'b1, 1'b1, 64'h300, "pre_rst");

        // Reset while stalled with a redirect pending.
        #1 reset = 1'b0;
        push_reset("rst_stall");
        @(negedge clk);
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 64'h0;
        reset         = 1'b1;
        repeat (4) step(1'b0, 1'b0, 64'h0, "restart");

        #2;
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL scoreboard: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
